// File: rtl/seq_det_param.sv
// Parameterised serial sequence detector.
// Detects a runtime-programmable pattern of 1..PAT_W bits on a serial stream.
// Provides both a same-cycle (Mealy) match flag and a registered copy one
// cycle later, overlap/non-overlap matching, a bit-enable and a saturating
// match counter.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   serIn        serial data bit
//   serEn        serIn valid this cycle; disabled cycles are ignored entirely
//   cfgLoad      capture cfgPattern/cfgLen/cfgOverlap; clears history
//   cfgPattern   new pattern, bit cfgLen-1 received first, bit 0 last
//   cfgLen       new pattern length (0 or >PAT_W clamps to PAT_W)
//   cfgOverlap   1 = overlapping matches allowed
//   cntClr       synchronous clear of matchCount (wins over increment)
//   seqValidPre  combinational match flag, same cycle as final pattern bit
//   seqValidPost registered match flag, one cycle after seqValidPre
//   matchCount   saturating match count
module seq_det_param #(
    parameter int unsigned      PAT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(8'h0F),
    parameter int unsigned      RST_LEN     = 4,
    parameter bit               RST_OVERLAP = 1'b1,
    parameter int unsigned      CNT_W       = 8,
    localparam int unsigned     LEN_W       = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serIn,
    input  logic             serEn,
    input  logic             cfgLoad,
    input  logic [PAT_W-1:0] cfgPattern,
    input  logic [LEN_W-1:0] cfgLen,
    input  logic             cfgOverlap,
    input  logic             cntClr,
    output logic             seqValidPre,
    output logic             seqValidPost,
    output logic [CNT_W-1:0] matchCount
);

    localparam logic [LEN_W-1:0] LenMax = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [PAT_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             post_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic             fill_ok;
    logic             match_now;

    // Candidate window: history plus the bit arriving this cycle.
    assign window  = {sh_q[PAT_W-2:0], serIn};
    // len_q is never 0, so len_q-1 cannot underflow.
    assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Gated by rst so the flag stays low while reset is held, whatever RST_LEN is.
    assign match_now = rst & serEn & ~cfgLoad & fill_ok &
                       (((window ^ pattern_q) & len_mask) == '0);

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        sh_d      = sh_q;
        fill_d    = fill_q;

        if (cfgLoad) begin
            pattern_d = cfgPattern;
            len_d     = (cfgLen == '0 || cfgLen > LenMax) ? LenMax : cfgLen;
            overlap_d = cfgOverlap;
            sh_d      = '0;
            fill_d    = '0;
        end else if (serEn) begin
            sh_d = window;
            if (match_now && !overlap_q) begin
                // Non-overlap: the next match must be built from fresh bits.
                fill_d = '0;
            end else if (fill_q < LenMax) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end

        cnt_d = cnt_q;
        if (cntClr) begin
            cnt_d = '0;
        end else if (match_now && cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            sh_q      <= '0;
            fill_q    <= '0;
            post_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            sh_q      <= sh_d;
            fill_q    <= fill_d;
            post_q    <= match_now;
            cnt_q     <= cnt_d;
        end
    end

    assign seqValidPre  = match_now;
    assign seqValidPost = post_q;
    assign matchCount   = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param. A driver issues one stimulus per clock
// and pushes the expected outputs for that cycle into a scoreboard; a monitor
// pops and compares on the falling edge. Expected values come from a
// list-based model: the received bits since the last clear are kept as a queue
// and the pattern is compared bit by bit against its tail.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serIn = 1'b0;
    logic       serEn = 1'b0;
    logic       cfgLoad = 1'b0;
    logic [7:0] cfgPattern = '0;
    logic [3:0] cfgLen = '0;
    logic       cfgOverlap = 1'b0;
    logic       cntClr = 1'b0;
    logic       pre8, post8, pre2, post2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .serIn(serIn), .serEn(serEn), .cfgLoad(cfgLoad),
        .cfgPattern(cfgPattern), .cfgLen(cfgLen), .cfgOverlap(cfgOverlap),
        .cntClr(cntClr), .seqValidPre(pre8), .seqValidPost(post8), .matchCount(cnt8)
    );

    seq_det_param #(.PAT_W(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .serIn(serIn), .serEn(serEn), .cfgLoad(cfgLoad),
        .cfgPattern(cfgPattern), .cfgLen(cfgLen), .cfgOverlap(cfgOverlap),
        .cntClr(cntClr), .seqValidPre(pre2), .seqValidPost(post2), .matchCount(cnt2)
    );

    typedef struct {
        bit pre;
        bit post;
        int cnt8;
        int cnt2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit   hist[$];         // received bits, oldest first
    bit [7:0] m_pat;
    int   m_len;
    bit   m_ov;
    bit   m_prev;
    int   m_cnt8;
    int   m_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat  = 8'h0F;
        m_len  = 4;
        m_ov   = 1'b1;
        m_prev = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
        hist.delete();
    endtask

    // Last m_len received bits (including din) equal pattern, first-received bit = pattern[len-1].
    function automatic bit model_match(input bit din);
        int n = hist.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            bit b = (k == 0) ? din : hist[n - k];
            if (b != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input bit r, input bit en, input bit din, input bit ld,
                         input bit [7:0] pat, input bit [3:0] len, input bit ov,
                         input bit clr);
        exp_t e;
        bit   m;
        @(posedge clk);
        #1;
        rst = r; serEn = en; serIn = din; cfgLoad = ld;
        cfgPattern = pat; cfgLen = len; cfgOverlap = ov; cntClr = clr;
        if (!r) begin
            model_reset();
            e = '{pre: 1'b0, post: 1'b0, cnt8: 0, cnt2: 0};
            sb.push_back(e);
        end else begin
            m = en && !ld && model_match(din);
            e = '{pre: m, post: m_prev, cnt8: m_cnt8, cnt2: m_cnt2};
            sb.push_back(e);
            m_prev = m;
            if (clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (m) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (ld) begin
                m_pat = pat;
                m_len = (len == 0 || len > 8) ? 8 : int'(len);
                m_ov  = ov;
                hist.delete();
            end else if (en) begin
                hist.push_back(din);
                if (hist.size() > 8) void'(hist.pop_front());
                if (m && !m_ov) hist.delete();
            end
        end
    endtask

    task automatic bit_in(input bit din);
        drive(1'b1, 1'b1, din, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic clr_cnt();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    endtask

    // serEn/serIn held high during load to exercise load priority.
    task automatic load(input bit [7:0] pat, input bit [3:0] len, input bit ov);
        drive(1'b1, 1'b1, 1'b1, 1'b1, pat, len, ov, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    // Counter after all prior edges, against a hand-derived constant.
    task automatic check_count(input string name, input int exp8);
        idle();
        @(negedge clk);
        #1;
        chk(name, cnt8, exp8);
    endtask

    task automatic burst_0_1_0();
        for (int i = 0; i < 2; i++) bit_in(1'b0);
        for (int i = 0; i < 10; i++) bit_in(1'b1);
        for (int i = 0; i < 2; i++) bit_in(1'b0);
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("seqValidPre", pre8, e.pre);
            chk("seqValidPost", post8, e.post);
            chk("matchCount", cnt8, e.cnt8);
            chk("matchCount_w2", cnt2, e.cnt2);
            chk("seqValidPre_w2", pre2, e.pre);
        end
    end

    initial begin
        model_reset();
        do_reset(3);

        // 1: defaults, overlapping 1111
        burst_0_1_0();
        check_count("t1_count", 7);

        // 2: non-overlap 1111
        clr_cnt();
        load(8'h0F, 4'd4, 1'b0);
        burst_0_1_0();
        check_count("t2_count", 2);

        // 3: 10110, overlap
        clr_cnt();
        load(8'b0001_0110, 4'd5, 1'b1);
        begin
            bit [12:0] s;
            s = 13'b1011011010110;
            for (int i = 12; i >= 0; i--) bit_in(s[i]);
        end
        check_count("t3_count", 3);

        // 4: gaps between enabled ones
        clr_cnt();
        load(8'h0F, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(1'b1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        end
        check_count("t4_count", 1);

        // 5: 2-bit counter saturation, then clear on a match cycle
        clr_cnt();
        load(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) bit_in(1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("t5_sat", cnt2, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("t5_clr", cnt2, 0);

        // 6: reset mid-sequence, then default pattern only
        load(8'h0F, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) bit_in(1'b1);
        do_reset(2);
        bit_in(1'b1);
        check_count("t6_after_rst", 0);
        bit_in(1'b0);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        check_count("t6_one_match", 1);
        clr_cnt();
        load(8'hFF, 4'd0, 1'b1);
        for (int i = 0; i < 7; i++) bit_in(1'b1);
        check_count("t6_len8_short", 0);
        bit_in(1'b1);
        check_count("t6_len8_full", 1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit r, en, din, ld, ov, clr;
            bit [7:0] pat;
            bit [3:0] len;
            r   = ($urandom_range(0, 149) != 0);
            en  = ($urandom_range(0, 3) != 0);
            din = ($urandom_range(0, 2) != 0);
            ld  = ($urandom_range(0, 39) == 0);
            pat = 8'($urandom);
            len = 4'($urandom_range(0, 10));
            ov  = 1'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            drive(r, en, din, ld, pat, len, ov, clr);
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
